// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM generator with its own us prescaler, a frame counter, and shadowed per-channel widths.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run enable; low holds the counters at 0 and forces the outputs low
//   wr_en        one-cycle position write strobe
//   wr_ch        target channel of the write (writes to channels >= N_CH are dropped)
//   wr_pos       position value; width = min(BASE_US + wr_pos, MAX_US)
//   pwm          servo pulse outputs, high while cntr_val < active width
//   frame_start  one-cycle pulse at the frame boundary, coincident with cntr_val = 0
//   cntr_val     current frame position in us
//
// Optional build macro SLEW_LIMIT_EN: when defined, each frame commit moves
// active widths toward the shadow by at most SLEW_STEP us.
module servo_pwm_multi #(
   parameter int N_CH      = 2,
   parameter int TICK_DIV  = 100,
   parameter int PERIOD_US = 20000,
   parameter int CNT_W     = 15,
   parameter int POS_W     = 11,
   parameter int BASE_US   = 1000,
   parameter int MAX_US    = 2000,
   parameter int RESET_POS = 500,
   parameter int SLEW_STEP = 10,
   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [POS_W-1:0] wr_pos,
   output logic [N_CH-1:0]  pwm,
   output logic             frame_start,
   output logic [CNT_W-1:0] cntr_val
);
   localparam int W  = CNT_W + 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // sum is formed wide enough that no wr_pos value can wrap before the clamp
   localparam int SW = ((W > POS_W) ? W : POS_W) + 1;
   localparam logic [W-1:0] RST_W = (BASE_US + RESET_POS > MAX_US) ? W'(MAX_US) : W'(BASE_US + RESET_POS);
`ifdef SLEW_LIMIT_EN
   localparam logic [W-1:0] STEP = W'(SLEW_STEP);
`else
   // all widths lie in 0..MAX_US, so a step of at least MAX_US always lands on the shadow
   localparam logic [W-1:0] STEP = W'((SLEW_STEP > MAX_US) ? SLEW_STEP : MAX_US);
`endif

   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0]  pwm_q, pwm_d;
   logic             fs_q, fs_d;
   logic [W-1:0]     sh_q [N_CH];
   logic [W-1:0]     sh_d [N_CH];
   logic [W-1:0]     act_q [N_CH];
   logic [W-1:0]     act_d [N_CH];
   logic             tick, wrap;
   logic [SW-1:0]    sum;
   logic [W-1:0]     wid;

   // move a toward s by at most STEP; compares before subtracting so nothing underflows
   function automatic logic [W-1:0] toward(input logic [W-1:0] a, input logic [W-1:0] s);
      if (s > a) return (s - a > STEP) ? a + STEP : s;
      return (a - s > STEP) ? a - STEP : s;
   endfunction

   assign tick = en && (presc_q == PW'(TICK_DIV - 1));
   assign wrap = tick && (cnt_q == CNT_W'(PERIOD_US - 1));
   assign sum  = SW'(BASE_US) + SW'(wr_pos);
   assign wid  = (sum > SW'(MAX_US)) ? W'(MAX_US) : W'(sum);

   always_comb begin
      presc_d = (en && !tick) ? presc_q + PW'(1) : '0;
      cnt_d   = (!en || wrap) ? '0 : tick ? cnt_q + CNT_W'(1) : cnt_q;
      fs_d    = wrap;
      for (int i = 0; i < N_CH; i++) begin
         // out-of-range channels match no index, so such writes fall away here
         sh_d[i]  = (wr_en && wr_ch == CH_W'(i)) ? wid : sh_q[i];
         // commit reads sh_q, so a write on the boundary edge waits for the next frame
         act_d[i] = wrap ? toward(act_q[i], sh_q[i]) : act_q[i];
         pwm_d[i] = en && ({1'b0, cnt_q} < act_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         cnt_q   <= '0;
         pwm_q   <= '0;
         fs_q    <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            sh_q[i]  <= RST_W;
            act_q[i] <= RST_W;
         end
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_d;
         fs_q    <= fs_d;
         sh_q    <= sh_d;
         act_q   <= act_d;
      end
   end

   assign pwm         = pwm_q;
   assign frame_start = fs_q;
   assign cntr_val    = cnt_q;
endmodule
